tx_pkt_arb: RTL and testbench
=============================

// Module: tx_pkt_arb
// PURPOSE
//  Parametrised successor to the two-source TX mux feeding the PHY.
//  Arbitrates NUM_CH packet-framed sop/eop/valid/ready sources (token, handshake, data, ...) onto one PHY TX stream.
//  Grants are packet-atomic. Output goes through a 2-entry skid FIFO, so no combinational path runs from tx_lp_ready to any ch_ready.
//  Adds fixed-priority or round-robin selection, orphan-beat dropping, cancel-terminated packets and status pulses.
// PARAMETERS
//  NUM_CH    2  number of source channels (>=2); channel i occupies slice i of every ch_* bus
//  DATA_W    8  beat data width
//  ARB_MODE  0  0 = fixed priority (lowest index wins); 1 = round-robin
//  CH_W      $clog2(NUM_CH)  grant index width (localparam)
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              asynchronous active-low reset
//  ch_sop       in   NUM_CH         per-channel start of packet
//  ch_eop       in   NUM_CH         per-channel end of packet
//  ch_valid     in   NUM_CH         per-channel beat valid
//  ch_cancel    in   NUM_CH         per-channel abort; beat with cancel=1 ends the packet
//  ch_data      in   NUM_CH*DATA_W  per-channel data, ch i = [i*DATA_W +: DATA_W]
//  ch_ready     out  NUM_CH         per-channel ready
//  tx_lp_sop    out  1              PHY sop
//  tx_lp_eop    out  1              PHY eop
//  tx_lp_valid  out  1              PHY valid
//  tx_lp_cancel out  1              PHY cancel
//  tx_lp_data   out  DATA_W         PHY data
//  tx_lp_ready  in   1              PHY ready
//  pkt_done     out  1              1-cycle pulse: PHY accepts a beat with eop|cancel
//  drop_pulse   out  1              1-cycle pulse: >=1 orphan beat dropped this cycle
//  busy         out  1              1 while in XFER or FIFO non-empty
//  grant_ch     out  CH_W           current or last granted channel
// BEHAVIOUR
//  Reset (async): FIFO empty, state IDLE, rr_ptr=0, grant_ch=0.
//   All tx_lp_* outputs, pkt_done and drop_pulse are 0; ch_ready is 0.
//  Beat acceptance: accept = ch_valid[g] & ch_ready[g].
//  Space: space = (fifo_cnt<2). The FIFO count is registered.
//  FSM IDLE:
//   cand = ch_valid & ch_sop. Pick g by mode:
//    mode 0: lowest index in cand.
//    mode 1: first index in cand at or after rr_ptr, wrapping modulo NUM_CH.
//   ch_ready[g] = space. On accept: grant_ch<=g, beat enters FIFO.
//   If that beat also has eop|cancel, stay IDLE (1-beat packet). Otherwise go to XFER.
//  FSM XFER:
//   ch_ready[grant_ch] = space; all other channels have ch_ready=0.
//   Beats are forwarded unchanged; a mid-packet sop is not checked.
//   On accept with eop|cancel: go to IDLE. In mode 1, rr_ptr <= (grant_ch+1) % NUM_CH.
//   Mode 1 also updates rr_ptr this way for 1-beat packets in IDLE.
//  Orphans (IDLE only):
//   Any channel with valid & !sop gets ch_ready=1 regardless of space. The beat is discarded and drop_pulse=1 next cycle.
//   An orphan never blocks a simultaneous grant on another channel.
//  Back-to-back: the cycle after a packet ends, IDLE can accept a new sop. No bubble at the input.
//  FIFO/output:
//   tx_lp_* shows the FIFO head; tx_lp_valid = (fifo_cnt!=0).
//   Latency: input accept at edge t puts the beat on tx_lp_* after edge t; 1 cycle when FIFO empty.
//   Head pops on tx_lp_valid & tx_lp_ready. Simultaneous push and pop keeps the count.
//   Push when full cannot happen because space gates ready.
//   Stall: output holds stable while tx_lp_ready=0. Order is preserved.
//  pkt_done = tx_lp_valid & tx_lp_ready & (tx_lp_eop|tx_lp_cancel). This is combinational, like the PHY handshake.
//  Reset mid-packet: the partial packet is lost with no eop emitted. Upstream must restart with sop.
// TESTING
//  T1 single pkt: ch1 sends sop A0, A1, eop A2; ch0 idle; tx_lp_ready=1.
//     -> tx_lp_data A0,A1,A2 on cycles t+1..t+3; sop only on A0, eop only on A2; pkt_done=1 on A2; grant_ch=1.
//  T2 fixed priority (ARB_MODE=0): ch0 and ch1 both present sop in the same cycle.
//     -> ch0 packet goes first; ch1 ready stays 0 until ch0 eop is accepted; ch1 sop is accepted the next cycle.
//  T3 round-robin (ARB_MODE=1, NUM_CH=3): all 3 channels continuously offer 2-beat packets.
//     -> grant order 0,1,2,0; rr_ptr wraps 2->0; no idle cycle between packets.
//  T4 backpressure: tx_lp_ready=0 for 5 cycles mid-packet.
//     -> FIFO fills to 2 and ch_ready drops to 0; output is stable throughout.
//     -> After ready=1, no beat is lost or duplicated.
//  T5 orphan + cancel: in IDLE ch1 presents valid with sop=0, data 0x55.
//     -> beat consumed, drop_pulse=1, nothing on PHY.
//     Then ch0 sends sop 0x01, then 0x02 with cancel=1.
//     -> PHY carries tx_lp_cancel=1 on 0x02; pkt_done=1; state returns to IDLE.
//  T6 reset mid-packet: assert rst_n=0 after 2 beats of a 4-beat packet.
//     -> all outputs 0 immediately; FIFO empty; a new sop is accepted after release.

Source files
------------

// File: rtl/tx_pkt_arb.sv
// tx_pkt_arb: packet-atomic NUM_CH-to-1 TX arbiter feeding the PHY through a 2-entry skid FIFO
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ch_sop/eop/valid/cancel/data    per-channel source beats (channel i = slice i)
//   ch_ready                        per-channel ready (registered FIFO count only, never tx_lp_ready)
//   tx_lp_sop/eop/valid/cancel/data PHY stream showing the FIFO head
//   tx_lp_ready                     PHY ready
//   pkt_done                        PHY accepted a beat carrying eop or cancel
//   drop_pulse                      orphan beat(s) were discarded in the previous cycle
//   busy                            packet in flight or FIFO non-empty
//   grant_ch                        current or last granted channel
module tx_pkt_arb #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int ARB_MODE = 0,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_sop,
    input  logic [NUM_CH-1:0]        ch_eop,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_cancel,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     tx_lp_sop,
    output logic                     tx_lp_eop,
    output logic                     tx_lp_valid,
    output logic                     tx_lp_cancel,
    output logic [DATA_W-1:0]        tx_lp_data,
    input  logic                     tx_lp_ready,
    output logic                     pkt_done,
    output logic                     drop_pulse,
    output logic                     busy,
    output logic [CH_W-1:0]          grant_ch
);
    typedef enum logic {IDLE, XFER} state_t;
    state_t state, state_nxt;
    logic [CH_W-1:0] rr_ptr, rr_nxt, sel, cur;
    logic [NUM_CH-1:0] cand, orphan, ready;
    logic [1:0] cnt;
    logic rd_ptr, wr_ptr, found, space, acc, last, pop;
    logic [DATA_W+2:0] mem [2];
    logic [DATA_W+2:0] head;
    assign cand   = ch_valid & ch_sop;
    assign orphan = (state == IDLE) ? ch_valid & ~ch_sop : '0;
    assign space  = cnt < 2'd2;
    // Search from rr_ptr upward with wrap; walking downward lets the closest hit win.
    // In fixed-priority mode rr_ptr never leaves 0, so this is a lowest-index search.
    always_comb begin
        int idx;
        idx = 0;
        sel = '0;
        found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (cand[idx]) begin
                sel = CH_W'(idx);
                found = 1'b1;
            end
        end
    end
    assign cur    = (state == IDLE) ? sel : grant_ch;
    assign acc    = (state == IDLE) ? found & space : ch_valid[cur] & space;
    assign last   = ch_eop[cur] | ch_cancel[cur];
    assign rr_nxt = (cur == CH_W'(NUM_CH - 1)) ? '0 : cur + CH_W'(1);
    // Orphans are consumed regardless of FIFO space so they never stall a grant.
    assign ready    = orphan | ((state == XFER || found) ? NUM_CH'(space) << cur : '0);
    assign ch_ready = rst_n ? ready : '0;
    always_comb begin
        state_nxt = state;
        if (acc) state_nxt = last ? IDLE : XFER;
    end
    assign head        = mem[rd_ptr];
    assign tx_lp_valid = cnt != 2'd0;
    assign {tx_lp_sop, tx_lp_eop, tx_lp_cancel, tx_lp_data} = tx_lp_valid ? head : '0;
    assign pop         = tx_lp_valid & tx_lp_ready;
    assign pkt_done    = pop & (tx_lp_eop | tx_lp_cancel);
    assign busy        = (state == XFER) | tx_lp_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_ch   <= '0;
            cnt        <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            drop_pulse <= |orphan;
            cnt        <= cnt + {1'b0, acc} - {1'b0, pop};
            if (pop) rd_ptr <= ~rd_ptr;
            if (acc) wr_ptr <= ~wr_ptr;
            if (acc && state == IDLE) grant_ch <= sel;
            if (ARB_MODE != 0 && acc && last) rr_ptr <= rr_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (acc) mem[wr_ptr] <= {ch_sop[cur], ch_eop[cur], ch_cancel[cur], ch_data[int'(cur)*DATA_W +: DATA_W]};
    end
endmodule

// File: tb/tb_tx_pkt_arb.sv
// tb_tx_pkt_arb: directed vector bench for tx_pkt_arb (fixed-priority 2-channel and round-robin 3-channel instances)
module tb_tx_pkt_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] sop0 = '0, eop0 = '0, val0 = '0, can0 = '0, ready0;
    logic [15:0] dat0 = '0;
    logic rdy0 = 1'b1, tv0, ts0, te0, tc0, done0, drop0, busy0;
    logic [7:0] td0;
    logic g0;

    logic [2:0] sop1 = '0, eop1 = '0, val1 = '0, can1 = '0, ready1;
    logic [23:0] dat1 = '0;
    logic rdy1 = 1'b1, tv1, ts1, te1, tc1, done1, drop1, busy1;
    logic [7:0] td1;
    logic [1:0] g1;

    tx_pkt_arb #(.NUM_CH(2), .DATA_W(8), .ARB_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .ch_sop(sop0), .ch_eop(eop0), .ch_valid(val0),
        .ch_cancel(can0), .ch_data(dat0), .ch_ready(ready0), .tx_lp_sop(ts0),
        .tx_lp_eop(te0), .tx_lp_valid(tv0), .tx_lp_cancel(tc0), .tx_lp_data(td0),
        .tx_lp_ready(rdy0), .pkt_done(done0), .drop_pulse(drop0), .busy(busy0), .grant_ch(g0)
    );

    tx_pkt_arb #(.NUM_CH(3), .DATA_W(8), .ARB_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ch_sop(sop1), .ch_eop(eop1), .ch_valid(val1),
        .ch_cancel(can1), .ch_data(dat1), .ch_ready(ready1), .tx_lp_sop(ts1),
        .tx_lp_eop(te1), .tx_lp_valid(tv1), .tx_lp_cancel(tc1), .tx_lp_data(td1),
        .tx_lp_ready(rdy1), .pkt_done(done1), .drop_pulse(drop1), .busy(busy1), .grant_ch(g1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] sop, eop, val, can;
        logic [15:0] data;
        logic rdy;
        logic [1:0] ready;
        logic ov, os, oe, oc;
        logic [7:0] od;
        logic done, drop, busy, g;
    } vec_t;

    vec_t vecs[30];

    task automatic run_vec(input int i);
        @(negedge clk);
        sop0 = vecs[i].sop;
        eop0 = vecs[i].eop;
        val0 = vecs[i].val;
        can0 = vecs[i].can;
        dat0 = vecs[i].data;
        rdy0 = vecs[i].rdy;
        #1;
        chk($sformatf("vec%0d {ready,v,s,e,c,data,done,drop,busy,g}", i),
            {ready0, tv0, ts0, te0, tc0, td0, done0, drop0, busy0, g0},
            {vecs[i].ready, vecs[i].ov, vecs[i].os, vecs[i].oe, vecs[i].oc, vecs[i].od,
             vecs[i].done, vecs[i].drop, vecs[i].busy, vecs[i].g});
    endtask

    int exp_g[4] = '{0, 1, 2, 0};
    logic [2:0] beat = '0;
    logic [2:0] acc1;

    initial begin
        //           sop    eop    val    can    data      rdy   ready  ov sop eop can data   done drop busy g
        // T1: ch1 three-beat packet
        vecs[0]  = '{2'b10, 2'b00, 2'b10, 2'b00, 16'hA000, 1'b1, 2'b10, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[1]  = '{2'b00, 2'b00, 2'b10, 2'b00, 16'hA100, 1'b1, 2'b10, 1, 1, 0, 0, 8'hA0, 0, 0, 1, 1};
        vecs[2]  = '{2'b00, 2'b10, 2'b10, 2'b00, 16'hA200, 1'b1, 2'b10, 1, 0, 0, 0, 8'hA1, 0, 0, 1, 1};
        vecs[3]  = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1, 0, 1, 0, 8'hA2, 1, 0, 1, 1};
        vecs[4]  = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1};
        // T2: simultaneous sop, ch0 wins, ch1 follows without bubble
        vecs[5]  = '{2'b11, 2'b00, 2'b11, 2'b00, 16'hC0B0, 1'b1, 2'b01, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[6]  = '{2'b10, 2'b01, 2'b11, 2'b00, 16'hC0B1, 1'b1, 2'b01, 1, 1, 0, 0, 8'hB0, 0, 0, 1, 0};
        vecs[7]  = '{2'b10, 2'b00, 2'b10, 2'b00, 16'hC000, 1'b1, 2'b10, 1, 0, 1, 0, 8'hB1, 1, 0, 1, 0};
        vecs[8]  = '{2'b00, 2'b10, 2'b10, 2'b00, 16'hC100, 1'b1, 2'b10, 1, 1, 0, 0, 8'hC0, 0, 0, 1, 1};
        vecs[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1, 0, 1, 0, 8'hC1, 1, 0, 1, 1};
        vecs[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1};
        // T4: five cycles of PHY backpressure mid-packet
        vecs[11] = '{2'b01, 2'b00, 2'b01, 2'b00, 16'h00D0, 1'b1, 2'b01, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[12] = '{2'b00, 2'b00, 2'b01, 2'b00, 16'h00D1, 1'b0, 2'b01, 1, 1, 0, 0, 8'hD0, 0, 0, 1, 0};
        vecs[13] = '{2'b00, 2'b00, 2'b01, 2'b00, 16'h00D2, 1'b0, 2'b00, 1, 1, 0, 0, 8'hD0, 0, 0, 1, 0};
        vecs[14] = '{2'b00, 2'b00, 2'b01, 2'b00, 16'h00D2, 1'b0, 2'b00, 1, 1, 0, 0, 8'hD0, 0, 0, 1, 0};
        vecs[15] = '{2'b00, 2'b00, 2'b01, 2'b00, 16'h00D2, 1'b0, 2'b00, 1, 1, 0, 0, 8'hD0, 0, 0, 1, 0};
        vecs[16] = '{2'b00, 2'b00, 2'b01, 2'b00, 16'h00D2, 1'b0, 2'b00, 1, 1, 0, 0, 8'hD0, 0, 0, 1, 0};
        vecs[17] = '{2'b00, 2'b00, 2'b01, 2'b00, 16'h00D2, 1'b1, 2'b00, 1, 1, 0, 0, 8'hD0, 0, 0, 1, 0};
        vecs[18] = '{2'b00, 2'b00, 2'b01, 2'b00, 16'h00D2, 1'b1, 2'b01, 1, 0, 0, 0, 8'hD1, 0, 0, 1, 0};
        vecs[19] = '{2'b00, 2'b01, 2'b01, 2'b00, 16'h00D3, 1'b1, 2'b01, 1, 0, 0, 0, 8'hD2, 0, 0, 1, 0};
        vecs[20] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1, 0, 1, 0, 8'hD3, 1, 0, 1, 0};
        vecs[21] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        // T5: orphan on ch1, then ch0 packet terminated by cancel
        vecs[22] = '{2'b00, 2'b00, 2'b10, 2'b00, 16'h5500, 1'b1, 2'b10, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[23] = '{2'b01, 2'b00, 2'b01, 2'b00, 16'h0001, 1'b1, 2'b01, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0};
        vecs[24] = '{2'b00, 2'b00, 2'b01, 2'b01, 16'h0002, 1'b1, 2'b01, 1, 1, 0, 0, 8'h01, 0, 0, 1, 0};
        vecs[25] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1, 0, 0, 1, 8'h02, 1, 0, 1, 0};
        vecs[26] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        // orphan on ch0 alongside a 1-beat packet on ch1
        vecs[27] = '{2'b10, 2'b10, 2'b11, 2'b00, 16'hE077, 1'b1, 2'b11, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[28] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1, 1, 1, 0, 8'hE0, 1, 1, 1, 1};
        vecs[29] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1};

        #2;
        chk("reset u0 {ready,v,data,done,drop,busy,g}", {ready0, tv0, td0, done0, drop0, busy0, g0}, 32'h0);
        chk("reset u1 {ready,v,data,busy,g}", {ready1, tv1, td1, busy1, g1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) run_vec(i);

        // T6: reset in the middle of a 4-beat packet
        @(negedge clk);
        sop0 = 2'b01; eop0 = '0; val0 = 2'b01; can0 = '0; dat0 = 16'h00F0; rdy0 = 1'b1;
        #1 chk("t6 ready sop", ready0, 2'b01);
        @(negedge clk);
        sop0 = '0; dat0 = 16'h00F1;
        #1 chk("t6 out F0", {tv0, ts0, td0}, {1'b1, 1'b1, 8'hF0});
        @(negedge clk);
        dat0 = 16'h00F2;
        #1 chk("t6 out F1", {tv0, ts0, td0}, {1'b1, 1'b0, 8'hF1});
        rst_n = 1'b0;
        #1 chk("t6 in reset {ready,v,s,e,c,data,done,drop,busy,g}",
               {ready0, tv0, ts0, te0, tc0, td0, done0, drop0, busy0, g0}, 32'h0);
        @(negedge clk);
        sop0 = '0; val0 = '0; dat0 = '0;
        rst_n = 1'b1;
        #1 chk("t6 after release {v,busy}", {tv0, busy0}, 2'b00);
        @(negedge clk);
        sop0 = 2'b10; eop0 = 2'b10; val0 = 2'b10; dat0 = 16'h6000;
        #1 chk("t6 new sop ready", ready0, 2'b10);
        @(negedge clk);
        sop0 = '0; eop0 = '0; val0 = '0; dat0 = '0;
        #1 chk("t6 new pkt {v,s,e,data,done,g}", {tv0, ts0, te0, td0, done0, g0},
               {1'b1, 1'b1, 1'b1, 8'h60, 1'b1, 1'b1});

        // T3: round-robin over three channels each offering 2-beat packets back to back
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                val1[i] = (k < 8);
                sop1[i] = (k < 8) & ~beat[i];
                eop1[i] = (k < 8) & beat[i];
                dat1[i*8 +: 8] = 8'(16 * i) + {7'd0, beat[i]};
            end
            #1;
            if (k < 8) chk($sformatf("rr ready cycle %0d", k), ready1, 32'(1 << exp_g[k/2]));
            if (k > 0) chk($sformatf("rr data cycle %0d", k), {tv1, td1}, {1'b1, 8'(16 * exp_g[(k-1)/2] + (k-1) % 2)});
            acc1 = ready1 & val1;
            @(posedge clk);
            for (int i = 0; i < 3; i++) if (acc1[i]) beat[i] = ~beat[i];
        end
        chk("rr final grant", g1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
